// File: rtl/edward_nm_sched_pkg.sv
// rtl/edward_nm_sched_pkg.sv - shared defaults and width helper for the multiplier scheduler
package edward_nm_sched_pkg;

    localparam int R_WIDTH_DEF = 256;
    localparam int MUL_LAT_DEF = 3;

    // Ceiling log2, never below 1 so single-entry indices still get a bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edward_nm_sched_rsp_fifo.sv
// rtl/edward_nm_sched_rsp_fifo.sv - first-word-fall-through response FIFO
module nm_rsp_fifo
    import edward_nm_sched_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_rdy
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == CW'(DEPTH));
    assign rd_vld  = (count != '0);
    assign rd_data = mem[rptr];
    assign wr_en   = wr_vld & ~full;
    assign rd_en   = rd_rdy & rd_vld;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
            end
            if (rd_en) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/edward_nm_sched.sv
// rtl/edward_nm_sched.sv - credit-gated round-robin scheduler in front of a pipelined constant multiplier
module edward_nm_sched
    import edward_nm_sched_pkg::*;
#(
    parameter int R_WIDTH   = R_WIDTH_DEF,
    parameter int N_REQ     = 4,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_vld,
    input  logic [N_REQ*R_WIDTH-1:0]   i_req_s,
    output logic [N_REQ-1:0]           o_req_rdy,
    output logic                       o_mul_vld,
    output logic [R_WIDTH-1:0]         o_mul_s,
    input  logic                       i_mul_vld,
    input  logic [2*R_WIDTH-1:0]       i_mul_t,
    output logic [N_REQ-1:0]           o_rsp_vld,
    output logic [N_REQ*2*R_WIDTH-1:0] o_rsp_t,
    input  logic [N_REQ-1:0]           i_rsp_rdy,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int TW = clog2(N_REQ);
    localparam int PW = TW + 1;
    localparam int CW = clog2(RSP_DEPTH + 1);

    logic [CW-1:0]      credit [N_REQ];
    logic [TW-1:0]      rr_ptr;
    logic [R_WIDTH-1:0] req_op [N_REQ];
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   pop;
    logic [N_REQ-1:0]   fifo_wr;
    logic [N_REQ-1:0]   fifo_full;
    logic [TW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [PW-1:0]      cand;

    logic [MUL_LAT:0]   tag_vld;
    logic [TW-1:0]      tag_idx [MUL_LAT+1];
    logic               tail_vld;
    logic [TW-1:0]      tail_idx;

    assign tail_vld  = tag_vld[MUL_LAT];
    assign tail_idx  = tag_idx[MUL_LAT];
    assign o_req_rdy = gnt;
    assign pop       = o_rsp_vld & i_rsp_rdy;

    // Eligibility looks only at registered credits, so a pop this cycle frees a slot next cycle.
    always_comb begin
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_op[k] = i_req_s[k*R_WIDTH +: R_WIDTH];
            elig[k]   = i_req_vld[k] & (credit[k] < CW'(RSP_DEPTH)) & ~i_rst;
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + PW'(i);
            if (cand >= PW'(N_REQ)) begin
                cand = cand - PW'(N_REQ);
            end
            if (!gnt_any && elig[cand[TW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[TW-1:0];
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (credit[k] != '0) begin
                o_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr    <= '0;
            o_mul_vld <= 1'b0;
            o_mul_s   <= '0;
        end else begin
            o_mul_vld <= gnt_any;
            if (gnt_any) begin
                o_mul_s <= req_op[gnt_idx];
                rr_ptr  <= (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);
            end
        end
    end

    // Stage 0 lines up with o_mul_vld; the last stage lines up with the multiplier output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_vld <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld    <= {tag_vld[MUL_LAT-1:0], gnt_any};
            tag_idx[0] <= gnt_idx;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (i_mul_vld != tail_vld) begin
            o_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                credit[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                case ({gnt[k], pop[k]})
                    2'b10:   credit[k] <= credit[k] + CW'(1);
                    2'b01:   credit[k] <= credit[k] - CW'(1);
                    default: credit[k] <= credit[k];
                endcase
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_rsp
        assign fifo_wr[k] = i_mul_vld & tail_vld & (tail_idx == TW'(k)) & ~fifo_full[k] & ~i_rst;

        nm_rsp_fifo #(
            .WIDTH (2 * R_WIDTH),
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr_vld  (fifo_wr[k]),
            .wr_data (i_mul_t),
            .full    (fifo_full[k]),
            .rd_vld  (o_rsp_vld[k]),
            .rd_data (o_rsp_t[k*2*R_WIDTH +: 2*R_WIDTH]),
            .rd_rdy  (i_rsp_rdy[k])
        );
    end

endmodule

// File: tb/tb_edward_nm_sched.sv
// tb/tb_edward_nm_sched.sv - self-checking bench for edward_nm_sched with a constant-multiplier model
module tb_edward_nm_sched;

    localparam int RW    = 256;
    localparam int NR    = 4;
    localparam int ML    = 3;
    localparam int DEPTH = 4;
    localparam logic [2*RW-1:0] MUL_C = 512'h1234;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*RW-1:0]  req_s_bus;
    logic [NR-1:0]     o_req_rdy;
    logic              o_mul_vld;
    logic [RW-1:0]     o_mul_s;
    logic              i_mul_vld;
    logic [2*RW-1:0]   i_mul_t;
    logic [NR-1:0]     o_rsp_vld;
    logic [NR*2*RW-1:0] o_rsp_t;
    logic [NR-1:0]     rsp_rdy = '0;
    logic              o_busy;
    logic              o_err;
    logic              inject = 1'b0;
    logic [RW-1:0]     ops [NR];

    always #5 clk = ~clk;

    always_comb begin
        req_s_bus = '0;
        for (int k = 0; k < NR; k++) begin
            req_s_bus[k*RW +: RW] = ops[k];
        end
    end

    edward_nm_sched #(
        .R_WIDTH   (RW),
        .N_REQ     (NR),
        .MUL_LAT   (ML),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_req_vld (req_vld),
        .i_req_s   (req_s_bus),
        .o_req_rdy (o_req_rdy),
        .o_mul_vld (o_mul_vld),
        .o_mul_s   (o_mul_s),
        .i_mul_vld (i_mul_vld),
        .i_mul_t   (i_mul_t),
        .o_rsp_vld (o_rsp_vld),
        .o_rsp_t   (o_rsp_t),
        .i_rsp_rdy (rsp_rdy),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    // External constant multiplier, held in reset by ~i_rst.
    logic          mul_rst_n;
    logic [ML-1:0] mp_vld = '0;
    logic [2*RW-1:0] mp_t [ML];
    assign mul_rst_n = ~i_rst;
    always @(posedge clk) begin
        if (!mul_rst_n) begin
            mp_vld <= '0;
        end else begin
            mp_vld  <= {mp_vld[ML-2:0], o_mul_vld};
            mp_t[0] <= {{RW{1'b0}}, o_mul_s} * MUL_C;
            for (int i = 1; i < ML; i++) mp_t[i] <= mp_t[i-1];
        end
    end
    assign i_mul_vld = mp_vld[ML-1] | inject;
    assign i_mul_t   = mp_t[ML-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    int m_credit [NR];
    logic m_last_vld = 1'b0;
    logic [RW-1:0] m_last_s = '0;
    logic m_err = 1'b0;
    logic [2*RW-1:0] q_data [NR][$];
    int q_cyc [NR][$];
    int dut_gnts = 0;
    logic [2*RW-1:0] rx1 [$];

    typedef struct {
        logic [NR-1:0] vld;
        logic [NR-1:0] rdy_exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [2*RW-1:0] act, input logic [2*RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_grant();
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (m_ptr + i) % NR;
            if (req_vld[k] && m_credit[k] < DEPTH) return NR'(1) << k;
        end
        return '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            m_credit[k] = 0;
            q_data[k].delete();
            q_cyc[k].delete();
        end
        m_ptr = 0;
        m_last_vld = 1'b0;
        m_err = 1'b0;
        cyc = 0;
    endtask

    // One clock: entered just after a negedge with inputs set, leaves at the next negedge.
    task automatic tick();
        logic [NR-1:0] eg;
        logic [NR-1:0] evld;
        logic busy_exp;
        #1;
        eg = model_grant();
        busy_exp = 1'b0;
        for (int k = 0; k < NR; k++) if (m_credit[k] != 0) busy_exp = 1'b1;
        if (o_req_rdy != '0) dut_gnts++;
        check("o_req_rdy", o_req_rdy, eg);
        check("o_mul_vld", o_mul_vld, m_last_vld);
        if (m_last_vld) check("o_mul_s", o_mul_s, m_last_s);
        check("o_busy", o_busy, busy_exp);
        check("o_err", o_err, m_err);
        for (int k = 0; k < NR; k++) evld[k] = (q_cyc[k].size() > 0) && (q_cyc[k][0] <= cyc);
        check("o_rsp_vld", o_rsp_vld, evld);
        for (int k = 0; k < NR; k++) begin
            if (evld[k] && rsp_rdy[k]) begin
                check("o_rsp_t", o_rsp_t[k*2*RW +: 2*RW], q_data[k][0]);
                if (k == 1) rx1.push_back(o_rsp_t[k*2*RW +: 2*RW]);
                void'(q_data[k].pop_front());
                void'(q_cyc[k].pop_front());
                m_credit[k]--;
            end
        end
        m_last_vld = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (eg[k]) begin
                q_data[k].push_back({{RW{1'b0}}, ops[k]} * MUL_C);
                q_cyc[k].push_back(cyc + ML + 2);
                m_credit[k]++;
                m_ptr = (k + 1) % NR;
                m_last_vld = 1'b1;
                m_last_s = ops[k];
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        req_vld = '1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_rdy", o_req_rdy, '0);
        check("rst_mul_vld", o_mul_vld, '0);
        check("rst_mul_s", o_mul_s, '0);
        check("rst_rsp_vld", o_rsp_vld, '0);
        check("rst_busy", o_busy, '0);
        check("rst_err", o_err, '0);
        i_rst = 1'b0;
        req_vld = '0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic drain();
        req_vld = '0;
        rsp_rdy = '1;
        repeat (12) tick();
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0010};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b0000, 4'b0000};
        tbl[8]  = '{4'b1001, 4'b1000};
        tbl[9]  = '{4'b1010, 4'b0010};
        tbl[10] = '{4'b0101, 4'b0100};
        tbl[11] = '{4'b0011, 4'b0001};
        tbl[12] = '{4'b1100, 4'b0100};
        for (int k = 0; k < NR; k++) ops[k] = RW'(100 + k);

        apply_reset();

        // Round-robin vectors
        rsp_rdy = '1;
        for (int i = 0; i < 13; i++) begin
            req_vld = tbl[i].vld;
            #1;
            check("tbl_grant", o_req_rdy, tbl[i].rdy_exp);
            tick();
        end
        drain();

        // Single request latency and data
        apply_reset();
        ops[0] = RW'(1);
        req_vld = 4'b0001;
        rsp_rdy = 4'b0001;
        tick();
        req_vld = '0;
        repeat (4) tick();
        #1;
        check("single_rsp_vld", o_rsp_vld[0], 1'b1);
        check("single_rsp_t", o_rsp_t[2*RW-1:0], 512'h1234);
        tick();
        tick();
        check("single_busy", o_busy, 1'b0);

        // Credit stall on requester 2
        req_vld = 4'b0100;
        rsp_rdy = '0;
        dut_gnts = 0;
        repeat (12) tick();
        check("stall_grants", dut_gnts, 4);
        #1;
        check("stall_rdy2", o_req_rdy[2], 1'b0);
        dut_gnts = 0;
        rsp_rdy = 4'b0100;
        tick();
        rsp_rdy = '0;
        repeat (8) tick();
        check("stall_regrant", dut_gnts, 1);
        drain();
        check("stall_busy", o_busy, 1'b0);

        // Per-requester ordering
        rx1.delete();
        req_vld = 4'b0010;
        rsp_rdy = 4'b0010;
        ops[1] = RW'(3); tick();
        ops[1] = RW'(5); tick();
        ops[1] = RW'(7); tick();
        req_vld = '0;
        repeat (10) tick();
        check("order_count", rx1.size(), 3);
        if (rx1.size() == 3) begin
            check("order_0", rx1[0], 512'd3 * MUL_C);
            check("order_1", rx1[1], 512'd5 * MUL_C);
            check("order_2", rx1[2], 512'd7 * MUL_C);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            req_vld = NR'($urandom());
            for (int k = 0; k < NR; k++) begin
                rsp_rdy[k] = ($urandom_range(0, 9) < 7);
                for (int j = 0; j < RW / 32; j++) ops[k][j*32 +: 32] = $urandom();
            end
            tick();
        end
        drain();

        // Reset two cycles after a grant
        ops[0] = RW'(9);
        req_vld = 4'b0001;
        tick();
        req_vld = '0;
        tick();
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        rsp_rdy = '1;
        repeat (10) tick();
        check("midrst_busy", o_busy, 1'b0);

        // Spurious multiplier result
        inject = 1'b1;
        tick();
        inject = 1'b0;
        m_err = 1'b1;
        repeat (5) tick();
        check("err_sticky", o_err, 1'b1);

        apply_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/edward_nm_sched.md
EDWARD_NM_SCHED -- requirements
Module: edward_nm_sched

Interface
REQ-001 SHALL have parameters: R_WIDTH, default 256, operand width; N_REQ, default 4, requester count; MUL_LAT, default 3, multiplier input-to-output latency in cycles; RSP_DEPTH, default 4, per-requester response buffer depth.
REQ-002 i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_vld  input  N_REQ  per-requester request valid.
REQ-005 i_req_s  input  N_REQ*R_WIDTH  per-requester operand; slice k = [k*R_WIDTH +: R_WIDTH].
REQ-006 o_req_rdy  output  N_REQ  per-requester accept; one-hot or zero.
REQ-007 o_mul_vld  output  1  registered issue strobe to the constant multiplier.
REQ-008 o_mul_s  output  R_WIDTH  registered operand to the multiplier.
REQ-009 i_mul_vld  input  1  multiplier result valid.
REQ-010 i_mul_t  input  2*R_WIDTH  multiplier result.
REQ-011 o_rsp_vld  output  N_REQ  per-requester response valid.
REQ-012 o_rsp_t  output  N_REQ*2*R_WIDTH  per-requester result; slice k = [k*2*R_WIDTH +: 2*R_WIDTH].
REQ-013 i_rsp_rdy  input  N_REQ  per-requester response accept.
REQ-014 o_busy  output  1  high while any credit counter is nonzero.
REQ-015 o_err  output  1  sticky protocol-error flag.

Function
REQ-016 Requester k SHALL be eligible when i_req_vld[k]=1 and credit[k] < RSP_DEPTH; credit[k] is the registered count of in-flight plus buffered results for k.
REQ-017 Grant SHALL go to the first eligible requester searching from rr_ptr upward, modulo N_REQ; o_req_rdy SHALL equal the grant combinationally; at most one grant per cycle.
REQ-018 After a grant to k, rr_ptr SHALL become (k+1) mod N_REQ; with no grant, rr_ptr SHALL hold.
REQ-019 On a grant at cycle T, o_mul_vld=1 and o_mul_s=operand k SHALL appear at T+1; otherwise o_mul_vld=0 and o_mul_s holds.
REQ-020 A tag shift register, MUL_LAT+1 stages of {valid, requester index}, SHALL align with i_mul_vld so the result arrives at T+1+MUL_LAT tagged k.
REQ-021 On i_mul_vld=1 with a valid aligned tag, i_mul_t SHALL be written to response FIFO k; o_rsp_vld[k] SHALL rise at T+2+MUL_LAT (T+5 at defaults).
REQ-022 Response pop SHALL occur when o_rsp_vld[k] and i_rsp_rdy[k]; FIFO order SHALL equal grant order per requester.
REQ-023 credit[k] SHALL increment on grant to k, decrement on pop from k, and hold when both occur in the same cycle; a same-cycle pop SHALL NOT make k eligible in that cycle.
REQ-024 Credit gating SHALL guarantee no FIFO overflow; FIFO full with credit below RSP_DEPTH is unreachable.
REQ-025 i_mul_vld=1 with an invalid aligned tag, or a valid tag with i_mul_vld=0, SHALL set o_err, which stays high until reset; the offending result SHALL be dropped.
REQ-026 Operand width SHALL pass unmodified; no arithmetic on data.

Reset
REQ-027 With i_rst high at a clock edge: o_mul_vld=0, o_mul_s=0, all tags invalid, all FIFOs empty, o_rsp_vld=0, credits=0, rr_ptr=0, o_busy=0, o_err=0, o_req_rdy=0.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered results; the top level SHALL drive the multiplier's i_rst_n from ~i_rst so no stale i_mul_vld follows.

Structure
REQ-029 A shared package SHALL hold the default R_WIDTH, MUL_LAT and the tag width function clog2(N_REQ).
REQ-030 One sub-module, nm_rsp_fifo (synchronous FIFO, width 2*R_WIDTH, depth RSP_DEPTH, first-word-fall-through), SHALL be instantiated N_REQ times; the multiplier SHALL remain external.

Verification
REQ-031 Single request: req0 vld with s=1 at T, multiplier model returns t=0x1234 -> o_mul_vld at T+1 with s=1, o_rsp_vld[0] at T+5 with t=0x1234, credit[0] returns to 0.
REQ-032 Round robin: all four requesters vld continuously, rsp_rdy=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-033 Credit stall: req2 vld continuously, i_rsp_rdy[2]=0 -> exactly 4 grants, then o_req_rdy[2]=0; one pop -> exactly one further grant, no earlier than the cycle after the pop.
REQ-034 Ordering: req1 issues s=3,5,7 back-to-back against the real multiplier -> responses in order equal 3*C, 5*C, 7*C, where C is the multiplier constant.
REQ-035 Reset mid-flight: assert i_rst 2 cycles after a grant -> no o_rsp_vld afterward, credits 0, o_err stays 0.
REQ-036 Protocol error: inject i_mul_vld=1 with no request outstanding -> o_err=1 next cycle and held; no o_rsp_vld.
